// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the write-back register file.
// Latency: n/a (declarations only). Backpressure: n/a (no handshakes in this block).
// Contents: default geometry (DATA_WIDTH, ADDR_WIDTH, REG_COUNT, COUNT_WIDTH),
//           the hardwired-zero register index and the address/data word types.
package regfile_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 5;
  localparam int REG_COUNT   = 2 ** ADDR_WIDTH;
  localparam int COUNT_WIDTH = 32;

  // Register 0 always reads zero; writes to it are thrown away.
  localparam int ZERO_REG    = 0;

  typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DATA_WIDTH-1:0] reg_data_t;

endpackage : regfile_pkg

// File: rtl/regfile_read_port.sv
// regfile_read_port: one ID-stage read mux with write-back forwarding.
// Latency: purely combinational, zero cycles. Backpressure: none, output always valid.
// Ports:
//   read_number    in   register select from ID
//   array_word     in   stored word for read_number, taken from the register array
//   write_enabled  in   write strobe from WB in the current cycle
//   write_number   in   destination register of that write
//   write_data     in   data of that write
//   read_data      out  zero for register 0, else forwarded WB data on a match, else array_word
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] read_number,
  input  logic [DATA_WIDTH-1:0] array_word,
  input  logic                  write_enabled,
  input  logic [ADDR_WIDTH-1:0] write_number,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic is_zero_reg;
  logic write_hit;

  assign is_zero_reg = (read_number == ADDR_WIDTH'(ZERO_REG));
  assign write_hit   = write_enabled && (write_number == read_number);

  // Zero check wins over the forward so a write aimed at register 0 can never
  // leak onto a read of register 0.
  always_comb begin
    read_data = array_word;
    if (is_zero_reg) begin
      read_data = '0;
    end else if (write_hit) begin
      read_data = write_data;
    end
  end

endmodule : regfile_read_port

// File: rtl/register_file_wb.sv
// register_file_wb: architectural register file fed by the WB stage, two forwarding read ports to ID.
// Latency: reads combinational (0 cycles); a write lands in the array at the next rising edge.
// Backpressure: none; every write to a non-zero register presented with reset low commits.
// Ports:
//   clock, reset                     rising-edge clock, asynchronous active-high reset
//   wb_write_enabled/_register_number/_data   write side from WB
//   id_read_number_a/b -> id_read_data_a/b    read ports to ID, same-cycle WB write forwarded
//   write_count                      committed writes since reset, wraps silently
//   dbg_read_number -> dbg_read_data present only with REGFILE_DEBUG_PORT_EN defined;
//                                    array-only view, no forwarding, no side effects
module register_file_wb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH  = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH  = regfile_pkg::ADDR_WIDTH,
  parameter int COUNT_WIDTH = regfile_pkg::COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wb_write_enabled,
  input  logic [ADDR_WIDTH-1:0]  wb_register_number,
  input  logic [DATA_WIDTH-1:0]  wb_data,
  input  logic [ADDR_WIDTH-1:0]  id_read_number_a,
  input  logic [ADDR_WIDTH-1:0]  id_read_number_b,
  output logic [DATA_WIDTH-1:0]  id_read_data_a,
  output logic [DATA_WIDTH-1:0]  id_read_data_b,
  output logic [COUNT_WIDTH-1:0] write_count
`ifdef REGFILE_DEBUG_PORT_EN
  ,
  input  logic [ADDR_WIDTH-1:0]  dbg_read_number,
  output logic [DATA_WIDTH-1:0]  dbg_read_data
`endif
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];
  logic [COUNT_WIDTH-1:0] write_count_q;
  logic [COUNT_WIDTH-1:0] write_count_d;
  logic                   commit;

  // A write to register 0 neither updates the array nor counts.
  assign commit = wb_write_enabled && (wb_register_number != ADDR_WIDTH'(ZERO_REG));

  always_comb begin
    regs_d        = regs_q;
    write_count_d = write_count_q;
    if (commit) begin
      regs_d[wb_register_number] = wb_data;
      write_count_d              = write_count_q + COUNT_WIDTH'(1);
    end
  end

  // Asynchronous clear: reset high empties the array at once and also drops
  // any write presented at an edge while it is held.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regs_q        <= '{default: '0};
      write_count_q <= '0;
    end else begin
      regs_q        <= regs_d;
      write_count_q <= write_count_d;
    end
  end

  assign write_count = write_count_q;

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port_a (
    .read_number   (id_read_number_a),
    .array_word    (regs_q[id_read_number_a]),
    .write_enabled (wb_write_enabled),
    .write_number  (wb_register_number),
    .write_data    (wb_data),
    .read_data     (id_read_data_a)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_read_port_b (
    .read_number   (id_read_number_b),
    .array_word    (regs_q[id_read_number_b]),
    .write_enabled (wb_write_enabled),
    .write_number  (wb_register_number),
    .write_data    (wb_data),
    .read_data     (id_read_data_b)
  );

`ifdef REGFILE_DEBUG_PORT_EN
  // Debug view shows committed state only, so a pending WB write is invisible here.
  always_comb begin
    dbg_read_data = regs_q[dbg_read_number];
    if (dbg_read_number == ADDR_WIDTH'(ZERO_REG)) begin
      dbg_read_data = '0;
    end
  end
`endif

endmodule : register_file_wb

// File: tb/tb_register_file_wb.sv
// tb_register_file_wb: self-checking bench for register_file_wb.
// A second, narrow-counter instance shares all inputs so counter wrap is reachable quickly.
// Honours REGFILE_DEBUG_PORT_EN when defined.
module tb_register_file_wb;
  import regfile_pkg::*;

  localparam int SCW = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            we;
  reg_addr_t       wnum, ra, rb;
  reg_data_t       wdata;
  reg_data_t       rd_a, rd_b, s_rd_a, s_rd_b;
  logic [31:0]     cnt;
  logic [SCW-1:0]  s_cnt;
`ifdef REGFILE_DEBUG_PORT_EN
  reg_addr_t       dbg_num;
  reg_data_t       dbg_dat, s_dbg_dat;
`endif

  always #5 clock = ~clock;

  register_file_wb dut (
    .clock(clock), .reset(reset),
    .wb_write_enabled(we), .wb_register_number(wnum), .wb_data(wdata),
    .id_read_number_a(ra), .id_read_number_b(rb),
    .id_read_data_a(rd_a), .id_read_data_b(rd_b),
    .write_count(cnt)
`ifdef REGFILE_DEBUG_PORT_EN
    , .dbg_read_number(dbg_num), .dbg_read_data(dbg_dat)
`endif
  );

  register_file_wb #(.COUNT_WIDTH(SCW)) dut_small (
    .clock(clock), .reset(reset),
    .wb_write_enabled(we), .wb_register_number(wnum), .wb_data(wdata),
    .id_read_number_a(ra), .id_read_number_b(rb),
    .id_read_data_a(s_rd_a), .id_read_data_b(s_rd_b),
    .write_count(s_cnt)
`ifdef REGFILE_DEBUG_PORT_EN
    , .dbg_read_number(dbg_num), .dbg_read_data(s_dbg_dat)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference state: what the architecture holds, updated only by committing writes.
  logic [31:0] model_regs [32];
  logic [31:0] model_cnt;

  typedef struct {
    logic        we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
    model_cnt = 32'h0;
  endtask

  task automatic model_commit();
    if (we && wnum != 5'd0) begin
      model_regs[wnum] = wdata;
      model_cnt        = model_cnt + 32'd1;
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] n);
    if (n == 5'd0) return 32'h0;
    if (we && wnum == n) return wdata;
    return model_regs[n];
  endfunction

  // One clock of model-checked traffic: drive at negedge, check reads before the edge,
  // check counters after it.
  task automatic cycle(input logic w, input logic [4:0] wn, input logic [31:0] wd,
                       input logic [4:0] a, input logic [4:0] b);
    @(negedge clock);
    we = w; wnum = wn; wdata = wd; ra = a; rb = b;
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_num = 5'($urandom_range(0, 31));
`endif
    #1;
    check("rand_rd_a", rd_a, exp_read(a));
    check("rand_rd_b", rd_b, exp_read(b));
    check("rand_small_rd_a", s_rd_a, exp_read(a));
`ifdef REGFILE_DEBUG_PORT_EN
    check("rand_dbg", dbg_dat, (dbg_num == 5'd0) ? 32'h0 : model_regs[dbg_num]);
`endif
    @(posedge clock);
    model_commit();
    #1;
    check("rand_cnt", cnt, model_cnt);
    check("rand_small_cnt", {28'h0, s_cnt}, {28'h0, model_cnt[SCW-1:0]});
  endtask

  initial begin
    reset = 1'b1;
    we = 1'b0; wnum = '0; wdata = '0; ra = '0; rb = '0;
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_num = '0;
`endif
    model_clear();

    //                 we    wnum   wdata          ra     rb     exp_a          exp_b          cnt
    vecs[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h00000000, 32'd1};
    vecs[1] = '{1'b0, 5'd0,  32'h00000000, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'd1};
    vecs[2] = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd7,  32'h12345678, 32'h12345678, 32'd2};
    vecs[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000, 32'd2};
    vecs[4] = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd7,  32'h00000000, 32'h12345678, 32'd2};
    vecs[5] = '{1'b1, 5'd5,  32'h00001111, 5'd5,  5'd2,  32'h00001111, 32'h00000000, 32'd3};
    vecs[6] = '{1'b0, 5'd5,  32'h99999999, 5'd5,  5'd31, 32'h00001111, 32'h00000000, 32'd3};
    vecs[7] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd30, 5'd31, 32'h00000000, 32'hCAFEF00D, 32'd4};
    vecs[8] = '{1'b0, 5'd31, 32'h0BADF00D, 5'd31, 5'd7,  32'hCAFEF00D, 32'h12345678, 32'd4};
    vecs[9] = '{1'b1, 5'd3,  32'hA5A5A5A5, 5'd3,  5'd0,  32'hA5A5A5A5, 32'h00000000, 32'd5};

    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Post-reset contents.
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      ra = 5'(i); rb = 5'(31 - i);
      #1;
      check("reset_rd_a", rd_a, 32'h0);
      check("reset_rd_b", rd_b, 32'h0);
    end
    check("reset_cnt", cnt, 32'h0);

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      we = vecs[i].we; wnum = vecs[i].wnum; wdata = vecs[i].wdata;
      ra = vecs[i].ra; rb = vecs[i].rb;
      #1;
      check("tbl_rd_a", rd_a, vecs[i].exp_a);
      check("tbl_rd_b", rd_b, vecs[i].exp_b);
      @(posedge clock);
      model_commit();
      #1;
      check("tbl_cnt", cnt, vecs[i].exp_cnt);
    end

    // Asynchronous reset in the middle of a cycle, no clock edge involved.
    @(negedge clock);
    we = 1'b0; ra = 5'd3; rb = 5'd5;
    #1;
    check("pre_rst_r3", rd_a, 32'hA5A5A5A5);
    reset = 1'b1;
    #1;
    check("async_rst_r3", rd_a, 32'h0);
    check("async_rst_r5", rd_b, 32'h0);
    check("async_rst_cnt", cnt, 32'h0);
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_num = 5'd3;
    #1;
    check("async_rst_dbg", dbg_dat, 32'h0);
`endif
    // Write under reset: forwarded to reads, but never committed.
    we = 1'b1; wnum = 5'd4; wdata = 32'h11111111; ra = 5'd4; rb = 5'd3;
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_num = 5'd4;
`endif
    #1;
    check("rst_bypass_a", rd_a, 32'h11111111);
    check("rst_bypass_b", rd_b, 32'h0);
`ifdef REGFILE_DEBUG_PORT_EN
    check("rst_dbg_nobyp", dbg_dat, 32'h0);
`endif
    @(posedge clock);
    #1;
    check("rst_write_cnt", cnt, 32'h0);
    @(negedge clock);
    reset = 1'b0; we = 1'b0;
    #1;
    check("rst_write_drop", rd_a, 32'h0);
    model_clear();

    // First write after release commits; then 15 more to wrap the 4-bit counter.
    cycle(1'b1, 5'd4, 32'h22222222, 5'd4, 5'd4);
    cycle(1'b0, 5'd0, 32'h0, 5'd4, 5'd3);
    check("first_after_rst", rd_a, 32'h22222222);
    check("first_after_cnt", cnt, 32'd1);
    for (int i = 0; i < 15; i++) cycle(1'b1, 5'd1, 32'(i), 5'd1, 5'd2);
    check("wrap_small_cnt", {28'h0, s_cnt}, 32'h0);
    check("wrap_big_cnt", cnt, 32'd16);

    // Randomised traffic, biased to few registers so bypass and overwrite collide often.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] wn, a, b;
      wn = 5'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 7));
      b  = ($urandom_range(0, 3) == 0) ? wn : 5'($urandom_range(0, 31));
      if ($urandom_range(0, 9) == 0) wn = 5'($urandom_range(8, 31));
      cycle(1'($urandom_range(0, 1)), wn, $urandom, a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_register_file_wb
